fire_scheduler: RTL and testbench

Round sequencer for the 3x3 fire/gold game. It produces its own game tick from `clk`, so the design needs no divided clock. Each round runs a warning phase, then an active-fire phase, then a gap. The block generates each round's fire pattern from a 9-bit LFSR, excluding gold cells and capping the fire count. It raises difficulty by shortening the tick period as rounds complete. It sits between the game FSM, which drives `run`, and the collision/score logic, which consumes `fire_state` and `fire_new`.

---
 rtl/fire_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_fire_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_scheduler.sv
// Round sequencer for the 3x3 fire/gold game: WARN -> ACTIVE -> GAP rounds paced by an
// internal tick, LFSR-generated fire patterns avoiding gold cells, and a level ramp.
module fire_scheduler #(
  parameter int         BASE_PERIOD      = 50_000_000,
  parameter int         PERIOD_STEP      = 5_000_000,
  parameter int         LEVEL_MAX        = 7,
  parameter int         ROUNDS_PER_LEVEL = 4,
  parameter int         WARN_TICKS       = 2,
  parameter int         ACTIVE_TICKS     = 3,
  parameter int         GAP_TICKS        = 1,
  parameter int         MAX_FIRES        = 4,
  parameter logic [8:0] SEED             = 9'b101000100,
  parameter int         CNT_W            = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       freeze,
  input  logic [8:0] gold_mask,
  output logic [1:0] phase,
  output logic [8:0] warn_state,
  output logic [8:0] fire_state,
  output logic       fire_new,
  output logic       round_done,
  output logic       tick,
  output logic [2:0] level
);

  typedef enum logic [1:0] {IDLE = 2'd0, WARN = 2'd1, ACTIVE = 2'd2, GAP = 2'd3} state_t;

  localparam int RW = (ROUNDS_PER_LEVEL < 2) ? 1 : $clog2(ROUNDS_PER_LEVEL);
  localparam int TW = 8;
  localparam int PW = CNT_W + 4;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, term;
  logic [TW-1:0]    ptick, ptick_nxt, ptick_last;
  logic [8:0]       lfsr, lfsr_nxt, lfsr_adv;
  logic [8:0]       pat, pat_nxt, new_pat;
  logic [RW-1:0]    rnd, rnd_nxt;
  logic [2:0]       level_nxt;
  logic [8:0]       warn_nxt, fire_nxt;
  logic             fire_new_nxt, round_done_nxt, tick_nxt;
  logic             start_round;
  logic [PW-1:0]    dec, base_p, period;
  logic [8:0]       cand, capped, fallback;
  logic             found;
  int               n;

  // Period shrinks with level and is floored at 2 so the counter always wraps.
  assign base_p = PW'(BASE_PERIOD);
  assign dec    = PW'(level) * PW'(PERIOD_STEP);
  assign period = ((dec + PW'(2)) > base_p) ? PW'(2) : (base_p - dec);
  assign term   = CNT_W'(period - PW'(1));

  assign lfsr_adv = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
  assign phase    = state;

  always_comb begin
    case (state)
      WARN:    ptick_last = TW'(WARN_TICKS - 1);
      ACTIVE:  ptick_last = TW'(ACTIVE_TICKS - 1);
      default: ptick_last = TW'(GAP_TICKS - 1);
    endcase
  end

  // Lowest-index MAX_FIRES candidates; fall back to the first non-gold cell.
  always_comb begin
    cand     = lfsr_adv & ~gold_mask;
    capped   = '0;
    fallback = '0;
    found    = 1'b0;
    n        = 0;
    for (int i = 0; i < 9; i++) begin
      if (cand[i] && (n < MAX_FIRES)) begin
        capped[i] = 1'b1;
        n = n + 1;
      end
    end
    for (int i = 0; i < 9; i++) begin
      if (!gold_mask[i] && !found) begin
        fallback[i] = 1'b1;
        found       = 1'b1;
      end
    end
    new_pat = (capped != '0) ? capped : fallback;
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ptick_nxt      = ptick;
    lfsr_nxt       = lfsr;
    pat_nxt        = pat;
    rnd_nxt        = rnd;
    level_nxt      = level;
    warn_nxt       = warn_state;
    fire_nxt       = fire_state;
    fire_new_nxt   = 1'b0;
    round_done_nxt = 1'b0;
    tick_nxt       = 1'b0;
    start_round    = 1'b0;
    if (!run) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      ptick_nxt = '0;
      pat_nxt   = '0;
      rnd_nxt   = '0;
      level_nxt = '0;
      warn_nxt  = '0;
      fire_nxt  = '0;
    end else if (freeze) begin
      // hold everything; pulses drop and the pending tick waits
    end else if (state == IDLE) begin
      cnt_nxt     = '0;
      ptick_nxt   = '0;
      start_round = 1'b1;
    end else if (cnt == term) begin
      cnt_nxt  = '0;
      tick_nxt = 1'b1;
      if (ptick == ptick_last) begin
        ptick_nxt = '0;
        case (state)
          WARN: begin
            state_nxt    = ACTIVE;
            warn_nxt     = '0;
            fire_nxt     = pat;
            fire_new_nxt = 1'b1;
          end
          ACTIVE: begin
            fire_nxt       = '0;
            round_done_nxt = 1'b1;
            if (rnd == RW'(ROUNDS_PER_LEVEL - 1)) begin
              rnd_nxt = '0;
              if (level != 3'(LEVEL_MAX)) level_nxt = level + 3'd1;
            end else begin
              rnd_nxt = rnd + RW'(1);
            end
            if (GAP_TICKS == 0) start_round = 1'b1;
            else state_nxt = GAP;
          end
          default: start_round = 1'b1;
        endcase
      end else begin
        ptick_nxt = ptick + TW'(1);
      end
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
    if (start_round) begin
      state_nxt = WARN;
      lfsr_nxt  = lfsr_adv;
      pat_nxt   = new_pat;
      warn_nxt  = new_pat;
      fire_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ptick      <= '0;
      lfsr       <= SEED;
      pat        <= '0;
      rnd        <= '0;
      level      <= '0;
      warn_state <= '0;
      fire_state <= '0;
      fire_new   <= 1'b0;
      round_done <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ptick      <= ptick_nxt;
      lfsr       <= lfsr_nxt;
      pat        <= pat_nxt;
      rnd        <= rnd_nxt;
      level      <= level_nxt;
      warn_state <= warn_nxt;
      fire_state <= fire_nxt;
      fire_new   <= fire_new_nxt;
      round_done <= round_done_nxt;
      tick       <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_fire_scheduler.sv
// Bench for fire_scheduler: directed round/gold/cap/abort/freeze/level scenarios plus a
// randomized run checked every cycle against a countdown-style reference model.
module tb_fire_scheduler;

  localparam int BASE = 4, STEP = 1, LMAX = 2, RPL = 2;
  localparam int WT = 2, AT = 3, GT = 1, MAXF = 4;

  logic       clk = 1'b0;
  logic       rst, run, freeze;
  logic [8:0] gold;
  logic [1:0] phase, b_phase;
  logic [8:0] warn_state, fire_state, b_warn, b_fire;
  logic       fire_new, round_done, tick, b_new, b_done, b_tick;
  logic [2:0] level, b_level;

  fire_scheduler #(
    .BASE_PERIOD(BASE), .PERIOD_STEP(STEP), .LEVEL_MAX(LMAX), .ROUNDS_PER_LEVEL(RPL),
    .WARN_TICKS(WT), .ACTIVE_TICKS(AT), .GAP_TICKS(GT), .MAX_FIRES(MAXF),
    .SEED(9'b101000100), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .freeze(freeze), .gold_mask(gold),
    .phase(phase), .warn_state(warn_state), .fire_state(fire_state),
    .fire_new(fire_new), .round_done(round_done), .tick(tick), .level(level)
  );

  fire_scheduler #(
    .BASE_PERIOD(BASE), .PERIOD_STEP(STEP), .LEVEL_MAX(LMAX), .ROUNDS_PER_LEVEL(RPL),
    .WARN_TICKS(WT), .ACTIVE_TICKS(AT), .GAP_TICKS(GT), .MAX_FIRES(MAXF),
    .SEED(9'b111111110), .CNT_W(8)
  ) dut_cap (
    .clk(clk), .rst(rst), .run(run), .freeze(freeze), .gold_mask(gold),
    .phase(b_phase), .warn_state(b_warn), .fire_state(b_fire),
    .fire_new(b_new), .round_done(b_done), .tick(b_tick), .level(b_level)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_seen = 0;
  logic [25:0] exp_q[$];

  // reference model state: countdowns to the next tick and to the end of the phase
  logic [1:0] m_phase;
  logic [8:0] m_lfsr, m_pat, m_warn, m_fire;
  logic       m_new, m_done, m_tick;
  logic [2:0] m_level;
  int         m_left, m_tk_left, m_rounds;

  task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_pattern(input logic [8:0] v, input logic [8:0] g);
    int idx[$];
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) if (v[i] && !g[i]) idx.push_back(i);
    while (idx.size() > MAXF) void'(idx.pop_back());
    foreach (idx[k]) r[idx[k]] = 1'b1;
    if (idx.size() == 0) begin
      for (int i = 0; i < 9; i++) begin
        if (!g[i]) begin
          r[i] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic int period_of(input int lv);
    int p;
    p = BASE - lv * STEP;
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_lfsr = 9'b101000100; m_pat = 0; m_warn = 0; m_fire = 0;
    m_new = 0; m_done = 0; m_tick = 0; m_level = 0;
    m_left = 0; m_tk_left = 0; m_rounds = 0;
  endtask

  task automatic model_start_round();
    m_lfsr    = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
    m_pat     = ref_pattern(m_lfsr, gold);
    m_phase   = 1;
    m_tk_left = WT;
    m_warn    = m_pat;
    m_fire    = 0;
  endtask

  task automatic model_edge();
    m_new = 0; m_done = 0; m_tick = 0;
    if (!run) begin
      m_phase = 0; m_warn = 0; m_fire = 0; m_level = 0; m_rounds = 0;
    end else if (freeze) begin
    end else if (m_phase == 0) begin
      model_start_round();
      m_left = period_of(int'(m_level));
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_tick = 1;
        m_tk_left--;
        if (m_tk_left == 0) begin
          case (m_phase)
            2'd1: begin
              m_phase = 2; m_tk_left = AT; m_warn = 0; m_fire = m_pat; m_new = 1;
            end
            2'd2: begin
              m_done = 1; m_fire = 0; m_rounds++;
              if (m_rounds == RPL) begin
                m_rounds = 0;
                if (int'(m_level) < LMAX) m_level = m_level + 3'd1;
              end
              if (GT > 0) begin
                m_phase = 3; m_tk_left = GT;
              end else model_start_round();
            end
            default: model_start_round();
          endcase
        end
        m_left = period_of(int'(m_level));
      end
    end
    if (m_done) rd_seen++;
  endtask

  function automatic logic [25:0] dut_vec();
    return {phase, warn_state, fire_state, fire_new, round_done, tick, level};
  endfunction

  // driver: advance model and DUT one edge, then score the cycle
  task automatic step();
    model_edge();
    exp_q.push_back({m_phase, m_warn, m_fire, m_new, m_done, m_tick, m_level});
    @(posedge clk);
    #1;
    cyc++;
    check("cycle_model", dut_vec(), exp_q.pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; freeze = 1'b0;
    #2;
    model_reset();
    check("reset_outputs", dut_vec(), 26'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_rounds(input int k);
    int guard;
    guard = 0;
    while (rd_seen < k && guard < 400) begin
      step();
      guard++;
    end
    check("round_wait_timeout", 26'(rd_seen >= k), 26'd1);
  endtask

  task automatic tick_gap(input int exp_gap, input string tag);
    int t1, guard;
    t1 = -1;
    guard = 0;
    while (guard < 40) begin
      step();
      guard++;
      if (tick === 1'b1) begin
        if (t1 < 0) t1 = cyc;
        else break;
      end
    end
    check(tag, 26'(cyc - t1), 26'(exp_gap));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; freeze = 1'b0; gold = 9'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_initial", dut_vec(), 26'd0);

    // first round, no gold
    do_reset();
    gold = 9'd0; run = 1'b1; cyc = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) begin
        check("warn_phase", 26'(phase), 26'd1);
        check("warn_pattern", 26'(warn_state), 26'(9'b010001001));
        check("warn_entry_no_tick", 26'(tick), 26'd0);
        check("cap_pattern", 26'(b_warn), 26'(9'b000111100));
      end
      if (c == 8) check("still_warn", 26'(phase), 26'd1);
      if (c == 9) begin
        check("active_phase", 26'(phase), 26'd2);
        check("active_fire", 26'(fire_state), 26'(9'b010001001));
        check("fire_new_pulse", 26'(fire_new), 26'd1);
        check("warn_cleared", 26'(warn_state), 26'd0);
      end
      if (c == 21) begin
        check("round_done_pulse", 26'(round_done), 26'd1);
        check("gap_phase", 26'(phase), 26'd3);
      end
      if (c == 25) check("rewarn_phase", 26'(phase), 26'd1);
    end

    // gold exclusion, then abort mid-ACTIVE
    do_reset();
    gold = 9'b000000001; run = 1'b1; cyc = 0;
    step();
    check("gold_excluded", 26'(warn_state), 26'(9'b010001000));
    while (cyc < 12) step();
    run = 1'b0;
    step();
    check("abort_phase", 26'(phase), 26'd0);
    check("abort_fire", 26'(fire_state), 26'd0);
    check("abort_level", 26'(level), 26'd0);
    check("abort_no_done", 26'(round_done), 26'd0);
    run = 1'b1; cyc = 0; rd_seen = 0;
    step();
    check("rerun_next_lfsr", 26'(warn_state), 26'(9'b100010010));

    // freeze for 10 cycles mid-ACTIVE delays the exit by 10
    while (cyc < 12) step();
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("freeze_hold_fire", 26'(fire_state), 26'(9'b100010010));
    end
    freeze = 1'b0;
    while (cyc < 31) begin
      step();
      if (cyc == 21) check("freeze_no_early_exit", 26'(round_done), 26'd0);
      if (cyc == 30) check("freeze_exit_not_yet", 26'(round_done), 26'd0);
    end
    check("freeze_exit_delayed", 26'(round_done), 26'd1);

    // level ramp and shrinking tick period
    gold = 9'd0;
    wait_rounds(2);
    check("level_after_2", 26'(level), 26'd1);
    tick_gap(3, "period_level1");
    wait_rounds(4);
    check("level_after_4", 26'(level), 26'd2);
    tick_gap(2, "period_level2");
    wait_rounds(6);
    check("level_saturated", 26'(level), 26'd2);

    // randomized run against the reference model
    for (int i = 0; i < 1500; i++) begin
      run    = ($urandom_range(0, 99) < 97);
      freeze = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 19) == 0) gold = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 99) == 0) gold = 9'h1ff;
      step();
    end

    // asynchronous reset mid-round, then the SEED pattern again
    run = 1'b1; freeze = 1'b0; gold = 9'd0;
    repeat (15) step();
    do_reset();
    run = 1'b1;
    step();
    check("post_reset_seed_pattern", 26'(warn_state), 26'(9'b010001001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
